// File: rtl/key_event_gen.sv
// key_event_gen: turns the sampled HID keycode level into press/repeat/release
// events and queues them in a small FIFO with a valid/ready handshake.
//
// Ports:
//   Clk, Reset     - clock, async active-high reset
//   keycode        - current HID keycode (8'h00 = no key)
//   frame_tick     - one-Clk pulse per video frame, paces key repeat
//   evt_ready      - consumer accepts the head event this cycle
//   evt_valid      - FIFO non-empty
//   evt_code       - keycode of head event (0 when empty)
//   evt_type       - 01 press, 10 repeat, 11 release (0 when empty)
//   held_code      - last-sampled keycode
//   fifo_overflow  - sticky, set when an event had to be dropped

module key_event_gen #(
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 6,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic [1:0] evt_type,
    output logic [7:0] held_code,
    output logic       fifo_overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [1:0] T_PRESS   = 2'b01;
    localparam logic [1:0] T_REPEAT  = 2'b10;
    localparam logic [1:0] T_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    // Key sampling and change detection
    logic [7:0] r_prev_code;
    logic       w_change;
    logic       w_rel;
    logic       w_press;

    assign w_change = (keycode != r_prev_code);
    assign w_rel    = w_change && (r_prev_code != 8'h00);
    assign w_press  = w_change && (keycode != 8'h00);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_prev_code <= 8'h00;
        else       r_prev_code <= keycode;
    end

    // Repeat FSM
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic              w_rpt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A key change takes priority over a due repeat and ignores the
    // frame_tick of the same edge, so the new delay starts untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rpt       = 1'b0;
        if (w_change) begin
            if (keycode != 8'h00) begin
                w_state_nxt = S_DELAY;
                w_cnt_nxt   = CNTW'(REPEAT_DELAY - 1);
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        end else if (frame_tick && (r_state != S_IDLE)) begin
            if (r_cnt == '0) begin
                w_rpt       = 1'b1;
                w_state_nxt = S_REPEAT;
                w_cnt_nxt   = CNTW'(REPEAT_PERIOD - 1);
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    // Event generation: at most two events per edge, release before press
    logic [1:0] w_n_ev;
    logic [9:0] w_ev0;
    logic [9:0] w_ev1;

    always_comb begin
        w_n_ev = 2'd0;
        w_ev0  = '0;
        w_ev1  = '0;
        if (w_rel && w_press) begin
            w_n_ev = 2'd2;
            w_ev0  = {T_RELEASE, r_prev_code};
            w_ev1  = {T_PRESS, keycode};
        end else if (w_rel) begin
            w_n_ev = 2'd1;
            w_ev0  = {T_RELEASE, r_prev_code};
        end else if (w_press) begin
            w_n_ev = 2'd1;
            w_ev0  = {T_PRESS, keycode};
        end else if (w_rpt) begin
            w_n_ev = 2'd1;
            w_ev0  = {T_REPEAT, r_prev_code};
        end
    end

    // Event FIFO
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [AW-1:0] w_wr_ptr1;
    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [1:0]    w_n_wr;
    logic          w_drop;
    logic [9:0]    w_head;

    assign evt_valid = (r_count != '0);
    assign w_pop     = evt_valid && evt_ready;
    assign w_wr_ptr1 = r_wr_ptr + 1'b1;
    // A pop this cycle frees its slot for a same-cycle write.
    assign w_free    = CW'(FIFO_DEPTH) - r_count + CW'(w_pop);
    assign w_drop    = (CW'(w_n_ev) > w_free);
    // When dropping, free space is below two, so its low bits are exact.
    assign w_n_wr    = w_drop ? w_free[1:0] : w_n_ev;

    always_ff @(posedge Clk) begin
        if (w_n_wr != 2'd0) r_mem[r_wr_ptr]  <= w_ev0;
        if (w_n_wr == 2'd2) r_mem[w_wr_ptr1] <= w_ev1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_wr);
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count + CW'(w_n_wr) - CW'(w_pop);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign evt_code      = evt_valid ? w_head[7:0] : 8'h00;
    assign evt_type      = evt_valid ? w_head[9:8] : 2'b00;
    assign held_code     = r_prev_code;
    assign fifo_overflow = r_ovf;

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed, self-checking bench for key_event_gen
// with REPEAT_DELAY=3, REPEAT_PERIOD=2, FIFO_DEPTH=4.

module tb_key_event_gen;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [1:0] evt_type;
    logic [7:0] held_code;
    logic       fifo_overflow;

    int n_tests;
    int n_fail;

    key_event_gen #(
        .REPEAT_DELAY (3),
        .REPEAT_PERIOD(2),
        .FIFO_DEPTH   (4)
    ) u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .frame_tick   (frame_tick),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .held_code    (held_code),
        .fifo_overflow(fifo_overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_ft();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [1:0] t,
                             input logic [7:0] c);
        chk({tag, ".valid"}, evt_valid, 1'b1);
        chk({tag, ".type"}, evt_type, t);
        chk({tag, ".code"}, evt_code, c);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        int  n;
        logic exp;
        n_tests    = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        keycode    = 8'h00;
        frame_tick = 1'b0;
        evt_ready  = 1'b0;
        tick();
        tick();
        chk("rst.valid", evt_valid, 1'b0);
        chk("rst.code", evt_code, 8'h00);
        chk("rst.type", evt_type, 2'b00);
        chk("rst.held", held_code, 8'h00);
        chk("rst.ovf", fifo_overflow, 1'b0);
        Reset = 1'b0;
        tick();

        // single press, held with no frame ticks
        evt_ready = 1'b1;
        keycode   = 8'h14;
        chk("press.pre", evt_valid, 1'b0);
        tick();
        chk("press.valid", evt_valid, 1'b1);
        chk("press.type", evt_type, 2'b01);
        chk("press.code", evt_code, 8'h14);
        chk("press.held", held_code, 8'h14);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_valid) n++;
        end
        chk("press.extra", n, 0);

        // release to empty, then 00->14->08 with consumer stalled
        keycode = 8'h00;
        tick();
        tick();
        chk("rel.drained", evt_valid, 1'b0);
        evt_ready = 1'b0;
        keycode   = 8'h14;
        tick();
        tick();
        tick();
        keycode = 8'h08;
        tick();
        pop_check("chg0", 2'b01, 8'h14);
        pop_check("chg1", 2'b11, 8'h14);
        pop_check("chg2", 2'b01, 8'h08);
        chk("chg.empty", evt_valid, 1'b0);

        // repeats on frame ticks 3, 5, 7
        evt_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            pulse_ft();
            exp = (i == 3) || (i == 5) || (i == 7);
            chk($sformatf("rpt%0d.valid", i), evt_valid, exp);
            if (exp) begin
                chk($sformatf("rpt%0d.type", i), evt_type, 2'b10);
                chk($sformatf("rpt%0d.code", i), evt_code, 8'h08);
            end
            tick();
        end
        keycode = 8'h00;
        tick();
        chk("rrel.valid", evt_valid, 1'b1);
        chk("rrel.type", evt_type, 2'b11);
        chk("rrel.code", evt_code, 8'h08);
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse_ft();
            chk($sformatf("norpt%0d", i), evt_valid, 1'b0);
            tick();
        end

        // overflow: 5 events into a 4-deep FIFO
        evt_ready = 1'b0;
        keycode   = 8'h14;
        tick();
        keycode = 8'h08;
        tick();
        keycode = 8'h00;
        tick();
        chk("ovf.before", fifo_overflow, 1'b0);
        keycode = 8'h14;
        tick();
        chk("ovf.set", fifo_overflow, 1'b1);
        // full FIFO popped this cycle still accepts one write
        keycode   = 8'h00;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        pop_check("ovf0", 2'b11, 8'h14);
        pop_check("ovf1", 2'b01, 8'h08);
        pop_check("ovf2", 2'b11, 8'h08);
        pop_check("ovf3", 2'b11, 8'h14);
        chk("ovf.empty", evt_valid, 1'b0);
        chk("ovf.sticky", fifo_overflow, 1'b1);

        // reset mid-DELAY with key still held
        keycode = 8'h14;
        tick();
        pulse_ft();
        Reset = 1'b1;
        #1;
        chk("mrst.valid", evt_valid, 1'b0);
        chk("mrst.held", held_code, 8'h00);
        chk("mrst.ovf", fifo_overflow, 1'b0);
        tick();
        tick();
        chk("mrst.hold", evt_valid, 1'b0);
        Reset = 1'b0;
        tick();
        pop_check("mrst.press", 2'b01, 8'h14);
        tick();
        chk("mrst.single", evt_valid, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            pulse_ft();
            exp = (i == 3);
            chk($sformatf("mrpt%0d.valid", i), evt_valid, exp);
            if (exp) pop_check("mrpt.evt", 2'b10, 8'h14);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
